// File: rtl/lamb_frame_receiver.sv
// rtl/lamb_frame_receiver.sv - 8N1 UART byte receiver feeding a 16-byte lamp frame parser
// (0xBB header, counter, 13 lamp bytes, 0xBB trailer) with inter-byte timeout.
module lamb_frame_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         sysClk,
  input  logic         sysRst,
  input  logic         Rx,
  output logic [7:0]   counter,
  output logic [103:0] lamb,
  output logic         frameValid,
  output logic         frameErr,
  output logic [7:0]   byteData,
  output logic         byteValid,
  output logic [1:0]   debugRxFsm
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int T_W      = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [T_W-1:0]  HALF_BIT  = T_W'(CLKS_PER_BIT / 2);
  localparam logic [T_W-1:0]  LAST_TICK = T_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hBB;

  typedef enum logic [1:0] {B_IDLE = 2'd0, B_START = 2'd1, B_DATA = 2'd2, B_STOP = 2'd3} bit_state_t;
  typedef enum logic [1:0] {F_HUNT = 2'd0, F_CNT = 2'd1, F_LAMB = 2'd2, F_TAIL = 2'd3} frm_state_t;

  logic             r_rx_meta, r_rx_sync;
  bit_state_t       r_bit_state, w_bit_next;
  logic [T_W-1:0]   r_bit_timer;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid, r_stop_err;
  logic             w_timer_clr, w_sample, w_byte_done, w_stop_bad;

  frm_state_t       r_frm_state, w_frm_next;
  logic [7:0]       r_shadow_cnt, r_counter;
  logic [103:0]     r_shadow_lamb, r_lamb;
  logic [3:0]       r_lamb_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_frame_valid, r_frame_err;
  logic             w_cnt_we, w_lamb_we, w_load, w_abort, w_timeout;

  assign counter    = r_counter;
  assign lamb       = r_lamb;
  assign frameValid = r_frame_valid;
  assign frameErr   = r_frame_err;
  assign byteData   = r_byte_data;
  assign byteValid  = r_byte_valid;
  assign debugRxFsm = r_bit_state;

  always_comb begin
    w_bit_next  = r_bit_state;
    w_timer_clr = 1'b0;
    w_sample    = 1'b0;
    w_byte_done = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_bit_state)
      B_IDLE: if (!r_rx_sync) begin
        w_bit_next  = B_START;
        w_timer_clr = 1'b1;
      end
      B_START: if (r_bit_timer == HALF_BIT) begin
        w_timer_clr = 1'b1;
        w_bit_next  = r_rx_sync ? B_IDLE : B_DATA;
      end
      B_DATA: if (r_bit_timer == LAST_TICK) begin
        w_timer_clr = 1'b1;
        w_sample    = 1'b1;
        if (r_bit_idx == 3'd7) w_bit_next = B_STOP;
      end
      B_STOP: if (r_bit_timer == LAST_TICK) begin
        w_timer_clr = 1'b1;
        w_bit_next  = B_IDLE;
        w_byte_done = r_rx_sync;
        w_stop_bad  = !r_rx_sync;
      end
      default: w_bit_next = B_IDLE;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_bit_state  <= B_IDLE;
      r_bit_timer  <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_rx_meta    <= Rx;
      r_rx_sync    <= r_rx_meta;
      r_bit_state  <= w_bit_next;
      r_bit_timer  <= (w_timer_clr || r_bit_state == B_IDLE) ? '0 : r_bit_timer + 1'b1;
      if (r_bit_state == B_START) r_bit_idx <= '0;
      else if (w_sample)          r_bit_idx <= r_bit_idx + 1'b1;
      // LSB arrives first, so shifting in from the top leaves it in bit 0
      if (w_sample) r_shift <= {r_rx_sync, r_shift[7:1]};
      if (w_byte_done) r_byte_data <= r_shift;
      r_byte_valid <= w_byte_done;
      r_stop_err   <= w_stop_bad;
    end
  end

  always_comb begin
    w_frm_next = r_frm_state;
    w_cnt_we   = 1'b0;
    w_lamb_we  = 1'b0;
    w_load     = 1'b0;
    w_abort    = 1'b0;
    w_timeout  = (r_frm_state != F_HUNT) && (r_bit_state == B_IDLE) &&
                 !r_byte_valid && (r_to_cnt == TO_LAST);
    case (r_frm_state)
      F_HUNT: if (r_byte_valid && r_byte_data == SYNC_BYTE) w_frm_next = F_CNT;
      F_CNT: if (r_byte_valid) begin
        w_cnt_we   = 1'b1;
        w_frm_next = F_LAMB;
      end
      F_LAMB: if (r_byte_valid) begin
        w_lamb_we = 1'b1;
        if (r_lamb_idx == 4'd12) w_frm_next = F_TAIL;
      end
      F_TAIL: if (r_byte_valid) begin
        w_frm_next = F_HUNT;
        w_load     = (r_byte_data == SYNC_BYTE);
        w_abort    = (r_byte_data != SYNC_BYTE);
      end
      default: w_frm_next = F_HUNT;
    endcase
    if (r_frm_state != F_HUNT && (r_stop_err || w_timeout)) begin
      w_abort    = 1'b1;
      w_frm_next = F_HUNT;
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst) begin
      r_frm_state   <= F_HUNT;
      r_shadow_cnt  <= '0;
      r_shadow_lamb <= '0;
      r_lamb_idx    <= '0;
      r_counter     <= '0;
      r_lamb        <= '0;
      r_to_cnt      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frm_state <= w_frm_next;
      if (w_cnt_we) r_shadow_cnt <= r_byte_data;
      // 13 shifts place the first lamp byte in the top slice
      if (w_lamb_we) r_shadow_lamb <= {r_shadow_lamb[95:0], r_byte_data};
      if (w_cnt_we)       r_lamb_idx <= '0;
      else if (w_lamb_we) r_lamb_idx <= r_lamb_idx + 1'b1;
      if (w_load) begin
        r_counter <= r_shadow_cnt;
        r_lamb    <= r_shadow_lamb;
      end
      // The byteValid cycle itself counts as the first idle cycle
      if (r_byte_valid)                r_to_cnt <= TO_W'(1);
      else if (r_frm_state == F_HUNT)  r_to_cnt <= '0;
      else if (r_bit_state == B_IDLE)  r_to_cnt <= r_to_cnt + 1'b1;
      r_frame_valid <= w_load;
      r_frame_err   <= w_abort;
    end
  end

endmodule

// File: tb/tb_lamb_frame_receiver.sv
// tb/tb_lamb_frame_receiver.sv - directed bench for lamb_frame_receiver at 8 clocks/bit, 20-bit timeout
module tb_lamb_frame_receiver;

  logic         sysClk = 1'b0;
  logic         sysRst = 1'b0;
  logic         Rx = 1'b1;
  logic [7:0]   counter;
  logic [103:0] lamb;
  logic         frameValid, frameErr;
  logic [7:0]   byteData;
  logic         byteValid;
  logic [1:0]   debugRxFsm;

  int checks = 0;
  int errors = 0;
  int cyc = 0, bv_cnt = 0, fv_cnt = 0, fe_cnt = 0, overlap = 0;
  int last_bv_cyc = 0, last_fe_cyc = 0;

  lamb_frame_receiver #(.CLKS_PER_BIT(8), .TIMEOUT_BITS(20)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .Rx(Rx),
    .counter(counter), .lamb(lamb), .frameValid(frameValid), .frameErr(frameErr),
    .byteData(byteData), .byteValid(byteValid), .debugRxFsm(debugRxFsm)
  );

  always #5 sysClk = ~sysClk;

  always @(negedge sysClk) begin
    cyc <= cyc + 1;
    if (byteValid) begin bv_cnt <= bv_cnt + 1; last_bv_cyc <= cyc; end
    if (frameValid) fv_cnt <= fv_cnt + 1;
    if (frameErr) begin fe_cnt <= fe_cnt + 1; last_fe_cyc <= cyc; end
    if (frameValid && frameErr) overlap <= overlap + 1;
  end

  typedef struct {
    logic [7:0]   hdr, cnt, base, trl;
    int           exp_fv, exp_fe;
    logic [7:0]   exp_cnt;
    logic [103:0] exp_lamb;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    Rx = 1'b0;
    idle(8);
    for (int k = 0; k < 8; k++) begin
      Rx = b[k];
      idle(8);
    end
    Rx = stop_bit;
    idle(8);
    Rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] cnt,
                            input logic [7:0] base, input logic [7:0] trl);
    logic [7:0] lb;
    send_byte(hdr, 1'b1);
    send_byte(cnt, 1'b1);
    for (int j = 0; j < 13; j++) begin
      lb = base + 8'(j);
      send_byte(lb, 1'b1);
    end
    send_byte(trl, 1'b1);
  endtask

  initial begin
    int s_bv, s_fv, s_fe;
    logic saw_start;

    vecs[0] = '{8'hBB, 8'h05, 8'h01, 8'hBB, 1, 0, 8'h05, 104'h0102030405060708090A0B0C0D};
    vecs[1] = '{8'hBB, 8'h22, 8'h10, 8'hAA, 0, 1, 8'h05, 104'h0102030405060708090A0B0C0D};
    vecs[2] = '{8'hBB, 8'h33, 8'h20, 8'hBB, 1, 0, 8'h33, 104'h202122232425262728292A2B2C};
    vecs[3] = '{8'hBB, 8'hBB, 8'hB5, 8'hBB, 1, 0, 8'hBB, 104'hB5B6B7B8B9BABBBCBDBEBFC0C1};

    repeat (5) @(negedge sysClk);
    check("rst_counter", 104'(counter), 104'h0);
    check("rst_lamb", lamb, 104'h0);
    check("rst_byteData", 104'(byteData), 104'h0);
    check("rst_pulses", 104'({frameValid, frameErr, byteValid}), 104'h0);
    check("rst_debug", 104'(debugRxFsm), 104'h0);
    sysRst = 1'b1;
    idle(10);

    for (int i = 0; i < 4; i++) begin
      s_bv = bv_cnt; s_fv = fv_cnt; s_fe = fe_cnt;
      send_frame(vecs[i].hdr, vecs[i].cnt, vecs[i].base, vecs[i].trl);
      idle(20);
      check($sformatf("vec%0d_fv", i), 104'(fv_cnt - s_fv), 104'(vecs[i].exp_fv));
      check($sformatf("vec%0d_fe", i), 104'(fe_cnt - s_fe), 104'(vecs[i].exp_fe));
      check($sformatf("vec%0d_bv", i), 104'(bv_cnt - s_bv), 104'd16);
      check($sformatf("vec%0d_counter", i), 104'(counter), 104'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_lamb", i), lamb, vecs[i].exp_lamb);
      check($sformatf("vec%0d_byteData", i), 104'(byteData), 104'(vecs[i].trl));
    end

    // Short low glitch on idle line
    s_bv = bv_cnt; s_fe = fe_cnt; saw_start = 1'b0;
    Rx = 1'b0;
    idle(3);
    Rx = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge sysClk);
      if (debugRxFsm == 2'd1) saw_start = 1'b1;
    end
    check("glitch_start_seen", 104'(saw_start), 104'h1);
    check("glitch_no_byte", 104'(bv_cnt - s_bv), 104'h0);
    check("glitch_no_err", 104'(fe_cnt - s_fe), 104'h0);
    check("glitch_debug_idle", 104'(debugRxFsm), 104'h0);

    // Inter-byte timeout
    s_fv = fv_cnt; s_fe = fe_cnt;
    send_byte(8'hBB, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(200);
    check("to_fe_count", 104'(fe_cnt - s_fe), 104'h1);
    check("to_latency", 104'(last_fe_cyc - last_bv_cyc), 104'd160);
    check("to_no_fv", 104'(fv_cnt - s_fv), 104'h0);
    check("to_counter_kept", 104'(counter), 104'hBB);
    check("to_lamb_kept", lamb, 104'hB5B6B7B8B9BABBBCBDBEBFC0C1);

    // Bad stop bit inside the lamp section
    s_bv = bv_cnt; s_fv = fv_cnt; s_fe = fe_cnt;
    send_byte(8'hBB, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    idle(30);
    check("stop_bv_count", 104'(bv_cnt - s_bv), 104'd3);
    check("stop_fe_count", 104'(fe_cnt - s_fe), 104'h1);
    check("stop_byteData_kept", 104'(byteData), 104'h01);
    idle(200);
    check("stop_hunt_no_timeout", 104'(fe_cnt - s_fe), 104'h1);
    check("stop_no_fv", 104'(fv_cnt - s_fv), 104'h0);

    // Back-to-back frames
    s_fv = fv_cnt; s_fe = fe_cnt;
    send_frame(8'hBB, 8'h01, 8'h00, 8'hBB);
    send_frame(8'hBB, 8'hBB, 8'h10, 8'hBB);
    idle(20);
    check("b2b_fv_count", 104'(fv_cnt - s_fv), 104'd2);
    check("b2b_no_fe", 104'(fe_cnt - s_fe), 104'h0);
    check("b2b_counter", 104'(counter), 104'hBB);
    check("b2b_lamb", lamb, 104'h101112131415161718191A1B1C);

    // Reset in the middle of the second of two back-to-back frames
    s_fv = fv_cnt;
    send_frame(8'hBB, 8'h01, 8'h00, 8'hBB);
    send_byte(8'hBB, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    Rx = 1'b0;
    idle(20);
    sysRst = 1'b0;
    idle(3);
    check("mid_rst_counter", 104'(counter), 104'h0);
    check("mid_rst_lamb", lamb, 104'h0);
    check("mid_rst_byteData", 104'(byteData), 104'h0);
    check("mid_rst_debug", 104'(debugRxFsm), 104'h0);
    Rx = 1'b1;
    idle(2);
    sysRst = 1'b1;
    idle(30);
    check("mid_rst_fv_only_first", 104'(fv_cnt - s_fv), 104'h1);
    check("mid_rst_counter_after", 104'(counter), 104'h0);

    send_frame(8'hBB, 8'h42, 8'h50, 8'hBB);
    idle(20);
    check("post_rst_counter", 104'(counter), 104'h42);
    check("post_rst_lamb", lamb, 104'h505152535455565758595A5B5C);

    check("no_fv_fe_overlap", 104'(overlap), 104'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamb_frame_receiver.md
LAMB_FRAME_RECEIVER -- requirements
Module: lamb_frame_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning sysClk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Parameter TIMEOUT_BITS, default 20, meaning maximum idle bit-times between bytes inside a frame.
REQ-003 sysClk  input  1  the single clock; all logic on its rising edge.
REQ-004 sysRst  input  1  synchronous, active-low reset.
REQ-005 Rx  input  1  asynchronous UART serial line, 8N1, LSB first, idle high.
REQ-006 counter  output  8  counter byte of the last good frame.
REQ-007 lamb  output  104  lamp vector of the last good frame.
REQ-008 frameValid  output  1  one-cycle pulse when counter/lamb update.
REQ-009 frameErr  output  1  one-cycle pulse on a frame abort.
REQ-010 byteData  output  8  last received byte.
REQ-011 byteValid  output  1  one-cycle pulse per accepted byte.
REQ-012 debugRxFsm  output  2  bit-level state code: IDLE=0, START=1, DATA=2, STOP=3.

Function
REQ-013 Rx SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal.
REQ-014 Bit FSM IDLE: a synchronized low level SHALL enter START and clear the bit timer.
REQ-015 START: at timer = CLKS_PER_BIT/2 (integer division), low -> DATA with timer cleared; high -> IDLE (glitch rejected, no byte).
REQ-016 DATA: every CLKS_PER_BIT cycles sample one bit into bit 0 first, bit 7 last; after 8 samples -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample; high -> byteData loaded and byteValid pulses on the next cycle; low -> byte discarded, no byteValid; both -> IDLE.
REQ-018 Frame format: 0xBB header, counter byte, 13 lamb bytes (first = lamb[103:96], last = lamb[7:0]), 0xBB trailer; 16 bytes total.
REQ-019 Frame FSM HUNT: byte 0xBB -> CNT; any other byte ignored, no frameErr.
REQ-020 CNT: any byte (0xBB included) -> shadow counter; -> LAMB with index 0.
REQ-021 LAMB: byte -> shadow lamb slice [103-8i:96-8i], i increments; after i = 12 -> TAIL.
REQ-022 TAIL: 0xBB -> counter/lamb load from shadow and frameValid pulses the cycle after that byteValid; any other byte -> frameErr pulse, outputs unchanged; both -> HUNT.
REQ-023 Timeout: in CNT/LAMB/TAIL with bit FSM in IDLE, a counter counts cycles since the last byteValid; reaching TIMEOUT_BITS*CLKS_PER_BIT -> frameErr pulse, -> HUNT.
REQ-024 A STOP-bit framing error inside CNT/LAMB/TAIL SHALL abort the frame: frameErr pulse, -> HUNT.
REQ-025 counter/lamb SHALL change only on frameValid; a partial or aborted frame never alters them.
REQ-026 frameValid and frameErr SHALL never assert in the same cycle.
REQ-027 Back-to-back frames with no idle gap SHALL all be received; a frame header may begin the bit after the prior trailer's stop bit.
REQ-028 Bit timer and timeout counter widths SHALL hold CLKS_PER_BIT and TIMEOUT_BITS*CLKS_PER_BIT without wrap.

Reset
REQ-029 While sysRst = 0 at a clock edge: bit FSM IDLE, frame FSM HUNT, synchronizer flops = 1, all timers 0.
REQ-030 While sysRst = 0: counter = 0x00, lamb = 0, byteData = 0x00, frameValid = byteValid = frameErr = 0, debugRxFsm = 0.
REQ-031 Reset asserted mid-byte or mid-frame SHALL discard all partial data; reception resumes at the first falling edge after release.

Verification (CLKS_PER_BIT = 8, TIMEOUT_BITS = 20)
REQ-032 Send BB 05 then 13 bytes 01..0D then BB -> one frameValid; counter = 0x05; lamb = 0x0102030405060708090A0B0C0D; 16 byteValid pulses.
REQ-033 Send 3 cycles low on idle Rx -> no byteValid; debugRxFsm returns to 0.
REQ-034 Valid frame with trailer 0xAA -> frameErr once; no frameValid; counter/lamb keep previous values; next valid frame accepted.
REQ-035 Send BB 07 01 02 then idle 200 cycles -> frameErr at cycle 160 after the last byteValid; outputs unchanged.
REQ-036 Byte with stop bit 0 during LAMB -> frameErr, no byteValid for that byte, frame FSM in HUNT.
REQ-037 Two back-to-back frames (counter 0x01, then 0xBB) -> two frameValid pulses; final counter = 0xBB; reset asserted mid-second-frame -> all outputs 0, no frameValid.
